// File: rtl/madd_scheduler_if.sv
// ============================================================================
// Module      : madd_scheduler_if
// Description : Requester, shared add_multiply and result signals of
//               madd_scheduler, with scheduler (slave) and environment
//               (master) views.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface madd_scheduler_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [14:0] req0_a;
    logic [14:0] req0_b;
    logic [14:0] req0_c;
    logic [14:0] req1_a;
    logic [14:0] req1_b;
    logic [14:0] req1_c;
    logic [14:0] mul_a;
    logic [14:0] mul_b;
    logic [14:0] mul_c;
    logic        mul_ce;
    logic [30:0] mul_y;
    logic        res_valid;
    logic        res_ready;
    logic        res_id;
    logic [30:0] res_y;
    logic        busy;
    logic [1:0]  fsm_state;

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_a, req0_b, req0_c, req1_a, req1_b, req1_c,
        input  mul_y, res_ready,
        output req0_ready, req1_ready,
        output mul_a, mul_b, mul_c, mul_ce,
        output res_valid, res_id, res_y, busy, fsm_state
    );

    modport master (
        output req0_valid, req1_valid,
        output req0_a, req0_b, req0_c, req1_a, req1_b, req1_c,
        output mul_y, res_ready,
        input  req0_ready, req1_ready,
        input  mul_a, mul_b, mul_c, mul_ce,
        input  res_valid, res_id, res_y, busy, fsm_state
    );
endinterface

`default_nettype wire

// File: rtl/madd_scheduler.sv
// ============================================================================
// Module      : madd_scheduler
// Description : Round-robin scheduler sharing one pipelined (A+B)*C unit
//               between two requesters, with tag pipeline and stall control.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module madd_scheduler #(
    parameter int LATENCY = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    madd_scheduler_if.slave    bus
);

    localparam int CNT_W = $clog2(LATENCY + 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    logic               ptr_q;
    logic [14:0]        mul_a_q;
    logic [14:0]        mul_b_q;
    logic [14:0]        mul_c_q;
    logic [LATENCY:0]   tag_v_q;
    logic [LATENCY:0]   tag_id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    state_t             state_q;

    logic w_ce;
    logic w_ready0;
    logic w_ready1;
    logic w_accept;
    logic w_gid;
    logic w_res_hs;

    // The pipeline only stalls when a finished result is refused downstream.
    always_comb begin
        w_ce     = !(tag_v_q[LATENCY] && !bus.res_ready);
        w_ready0 = w_ce && bus.req0_valid && (!bus.req1_valid || !ptr_q);
        w_ready1 = w_ce && bus.req1_valid && (!bus.req0_valid ||  ptr_q);
        w_accept = w_ready0 || w_ready1;
        w_gid    = w_ready1;
        w_res_hs = tag_v_q[LATENCY] && bus.res_ready;
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({w_accept, w_res_hs})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            mul_c_q  <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
        end else begin
            if (w_accept) begin
                ptr_q   <= ~w_gid;
                mul_a_q <= w_gid ? bus.req1_a : bus.req0_a;
                mul_b_q <= w_gid ? bus.req1_b : bus.req0_b;
                mul_c_q <= w_gid ? bus.req1_c : bus.req0_c;
            end
            // Tags advance in lockstep with the shared unit's own enable.
            if (w_ce) begin
                tag_v_q  <= {tag_v_q[LATENCY-1:0],  w_accept};
                tag_id_q <= {tag_id_q[LATENCY-1:0], w_gid};
            end
            cnt_q <= cnt_d;
            if (cnt_q == '0) begin
                state_q <= ST_IDLE;
            end else if (!w_ce) begin
                state_q <= ST_STALL;
            end else begin
                state_q <= ST_RUN;
            end
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.mul_c      = mul_c_q;
    assign bus.mul_ce     = w_ce;
    assign bus.res_valid  = tag_v_q[LATENCY];
    assign bus.res_id     = tag_id_q[LATENCY];
    assign bus.res_y      = bus.mul_y;
    assign bus.busy       = (cnt_q != '0);
    assign bus.fsm_state  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_madd_scheduler.sv
// ============================================================================
// Module      : tb_madd_scheduler
// Description : Directed self-checking bench for madd_scheduler with a
//               behavioural model of the shared (A+B)*C unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_madd_scheduler;

    localparam int LAT = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    madd_scheduler_if bus ();

    madd_scheduler #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [30:0] madd(input logic [14:0] a, input logic [14:0] b,
                                         input logic [14:0] c);
        int s;
        s = (int'($signed(a)) + int'($signed(b))) * int'($signed(c));
        return 31'(s);
    endfunction

    function automatic logic [31:0] y31(input int v);
        logic [31:0] t;
        t = v;
        return {1'b0, t[30:0]};
    endfunction

    // Shared add_multiply unit: LATENCY enabled edges from operands to product.
    logic [30:0] mp [LAT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) mp[i] <= '0;
        end else if (bus.mul_ce) begin
            mp[0] <= madd(bus.mul_a, bus.mul_b, bus.mul_c);
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
    end
    assign bus.mul_y = mp[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input int a, input int b, input int c);
        bus.req0_a = 15'(a); bus.req0_b = 15'(b); bus.req0_c = 15'(c);
    endtask

    task automatic set1(input int a, input int b, input int c);
        bus.req1_a = 15'(a); bus.req1_b = 15'(b); bus.req1_c = 15'(c);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.res_ready  = 1'b1;
        set0(0, 0, 0);
        set1(0, 0, 0);

        // Reset takes effect before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_id",    32'(bus.res_id),    32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_mul_ce",    32'(bus.mul_ce),    32'd1);
        chk("rst_mul_a",     32'(bus.mul_a),     32'd0);
        chk("rst_res_y",     32'(bus.res_y),     32'd0);
        chk("rst_state",     32'(bus.fsm_state), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single request, latency and value
        bus.req0_valid = 1'b1; set0(1, 2, 4);
        #1;
        chk("t1_rdy0", 32'(bus.req0_ready), 32'd1);
        chk("t1_rdy1", 32'(bus.req1_ready), 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t1_busy", 32'(bus.busy),  32'd1);
        chk("t1_mul_a", 32'(bus.mul_a), 32'd1);
        chk("t1_mul_c", 32'(bus.mul_c), 32'd4);
        tick();
        tick();
        #1;
        chk("t1_early", 32'(bus.res_valid), 32'd0);
        tick();
        #1;
        chk("t1_res_valid", 32'(bus.res_valid), 32'd1);
        chk("t1_res_id",    32'(bus.res_id),    32'd0);
        chk("t1_res_y",     32'(bus.res_y),     y31(12));
        tick();
        #1;
        chk("t1_done_valid", 32'(bus.res_valid), 32'd0);
        chk("t1_done_busy",  32'(bus.busy),      32'd0);

        // Signed operands from requester 1
        bus.req1_valid = 1'b1; set1(-3, 1, -5);
        #1;
        chk("t2_rdy1_a", 32'(bus.req1_ready), 32'd1);
        tick();
        set1(16383, 16383, -16384);
        #1;
        chk("t2_rdy1_b", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("t2_valid_a", 32'(bus.res_valid), 32'd1);
        chk("t2_id_a",    32'(bus.res_id),    32'd1);
        chk("t2_y_a",     32'(bus.res_y),     y31(10));
        tick();
        #1;
        chk("t2_valid_b", 32'(bus.res_valid), 32'd1);
        chk("t2_y_b",     32'(bus.res_y),     y31(-536838144));
        tick();
        #1;
        chk("t2_done", 32'(bus.res_valid), 32'd0);

        // Round-robin with both requesters valid; results overlap new accepts
        set0(1, 1, 1);
        set1(2, 1, 3);
        for (int i = 0; i < 10; i++) begin
            bus.req0_valid = (i < 6);
            bus.req1_valid = (i < 6);
            #1;
            if (i < 6) begin
                chk("t3_rdy0", 32'(bus.req0_ready), 32'((i % 2) == 0));
                chk("t3_rdy1", 32'(bus.req1_ready), 32'((i % 2) == 1));
            end
            if (i >= 4) begin
                chk("t3_res_valid", 32'(bus.res_valid), 32'd1);
                chk("t3_res_id",    32'(bus.res_id),    32'((i - 4) % 2));
                chk("t3_res_y",     32'(bus.res_y),     ((i - 4) % 2) == 1 ? y31(9) : y31(2));
            end
            if (i >= 1) chk("t3_busy", 32'(bus.busy), 32'd1);
            chk("t3_ce", 32'(bus.mul_ce), 32'd1);
            tick();
        end
        #1;
        chk("t3_done_valid", 32'(bus.res_valid), 32'd0);
        chk("t3_done_busy",  32'(bus.busy),      32'd0);

        // Downstream stall for three cycles
        bus.req0_valid = 1'b1; set0(3, 4, 5);
        #1;
        chk("t4_rdy0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; set1(1, 1, -1);
        #1;
        chk("t4_rdy1", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        tick();
        bus.res_ready  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_ce",    32'(bus.mul_ce),     32'd0);
            chk("t4_rdy0s", 32'(bus.req0_ready), 32'd0);
            chk("t4_rdy1s", 32'(bus.req1_ready), 32'd0);
            chk("t4_hold_v",  32'(bus.res_valid), 32'd1);
            chk("t4_hold_id", 32'(bus.res_id),    32'd0);
            chk("t4_hold_y",  32'(bus.res_y),     y31(35));
            tick();
        end
        bus.res_ready  = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("t4_rel_valid", 32'(bus.res_valid), 32'd1);
        chk("t4_rel_y",     32'(bus.res_y),     y31(35));
        tick();
        #1;
        chk("t4_next_valid", 32'(bus.res_valid), 32'd1);
        chk("t4_next_id",    32'(bus.res_id),    32'd1);
        chk("t4_next_y",     32'(bus.res_y),     y31(-2));
        tick();
        #1;
        chk("t4_done_valid", 32'(bus.res_valid), 32'd0);
        chk("t4_done_busy",  32'(bus.busy),      32'd0);

        // Reset with three operations in flight
        bus.req0_valid = 1'b1; set0(1, 1, 1);
        tick();
        tick();
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t5_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(bus.res_valid), 32'd0);
        chk("t5_rst_busy",  32'(bus.busy),      32'd0);
        chk("t5_rst_mul_a", 32'(bus.mul_a),     32'd0);
        chk("t5_rst_mul_b", 32'(bus.mul_b),     32'd0);
        chk("t5_rst_ce",    32'(bus.mul_ce),    32'd1);
        chk("t5_rst_y",     32'(bus.res_y),     32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t5_no_stale", 32'(bus.res_valid), 32'd0);
            tick();
        end
        bus.req0_valid = 1'b1; set0(0, 5, -2);
        #1;
        chk("t5_rdy0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("t5_early", 32'(bus.res_valid), 32'd0);
        tick();
        #1;
        chk("t5_valid", 32'(bus.res_valid), 32'd1);
        chk("t5_id",    32'(bus.res_id),    32'd0);
        chk("t5_y",     32'(bus.res_y),     y31(-10));
        tick();
        #1;
        chk("t5_done_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
